gameplay_input_ctrl: RTL and testbench
======================================

// Module: gameplay_input_ctrl
// PURPOSE
// - Drives the gameplay core's control inputs (new_game, charging_hit, camera_pan_left/right, new_frame).
// - Synchronises and debounces the raw board buttons, and derives the per-frame tick.
// - Reads back the core's state_out so a hit is only issued when the ball is at rest.
// - Sits between the board I/O and the gameplay core in the top level.
// PARAMETERS
// - DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles before a button changes (10 ms @ 100 MHz)
// - NEW_GAME_CYCLES  4          length of every new_game pulse, in cycles
// - VSYNC_POL        1          active level of vsync_in; new_frame fires on its active edge
// - FRAME_CYCLES     1_666_667  internal frame period (60 Hz @ 100 MHz); used only with FRAME_TIMER_EN
// PORTS
// - clk_in           in   1  system clock, 100 MHz
// - rst_n_in         in   1  asynchronous, active-low reset
// - btn_hit_in       in   1  raw hit button; asynchronous, bouncy
// - btn_left_in      in   1  raw pan-left button
// - btn_right_in     in   1  raw pan-right button
// - btn_reset_in     in   1  raw new-game button
// - vsync_in         in   1  video vsync; asynchronous
// - gameplay_state_in in  3  state_out from the core (0=RESTING, 1=CHARGING_HIT, 2..5 other)
// - new_game         out  1  synchronous reset to the core
// - charging_hit     out  1  level; high while a hit is being charged
// - camera_pan_left  out  1  level
// - camera_pan_right out  1  level
// - new_frame        out  1  one-cycle pulse per frame
// - frame_count      out 16  frames since the last new_game; wraps modulo 2^16
// BEHAVIOUR
// - Reset values (rst_n_in low): new_game=1; every other output 0; all counters 0; hit FSM in H_IDLE.
// - Input synchronisers: each of the 5 raw inputs passes through a 2-flop synchroniser.
// - Debounce (per button):
//   - The stable value updates only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles.
//   - Any cycle where the synced input equals the stable value clears the counter.
//   - Latency from raw edge to stable edge = 2 + DEBOUNCE_CYCLES cycles.
// - new_game:
//   - Goes high for NEW_GAME_CYCLES cycles starting on the first clock after reset release.
//   - Also goes high for NEW_GAME_CYCLES cycles on each debounced rising edge of the reset button.
//   - A new rising edge during an active pulse restarts the count.
//   - While new_game is high: the hit FSM is forced to H_IDLE, charging_hit=0, both pan outputs=0, frame_count=0.
// - Pan outputs (registered):
//   - camera_pan_left = db_left & ~db_right; camera_pan_right = db_right & ~db_left.
//   - Both buttons pressed gives 0/0.
// - Hit FSM, states {H_IDLE, H_ARMED, H_CHARGE}:
//   - H_IDLE -> H_ARMED when gameplay_state_in==0 and db_hit==0. A button already held when the ball stops therefore needs a release first.
//   - H_ARMED -> H_CHARGE when db_hit==1. H_ARMED -> H_IDLE when gameplay_state_in is not 0 or 1.
//   - H_CHARGE -> H_IDLE when db_hit==0 (this is the release that launches the ball).
//   - charging_hit is registered: 1 exactly while the FSM is in H_CHARGE, so it rises one cycle after the FSM enters H_CHARGE.
// - new_frame:
//   - One-cycle pulse on the synced vsync edge into VSYNC_POL; 3 cycles after the raw edge.
//   - Never two pulses in consecutive cycles.
//   - Still pulses while new_game is high.
// - frame_count increments by 1 in the same cycle new_frame is asserted; 0xFFFF wraps to 0x0000.
// - If new_game and new_frame coincide, clear wins: frame_count=0.
// CONFIGURATION
// - FRAME_TIMER_EN defined:
//   - new_frame comes from an internal counter 0..FRAME_CYCLES-1, which pulses on wrap.
//   - The first pulse comes FRAME_CYCLES cycles after reset release.
//   - vsync_in and VSYNC_POL are ignored.
// - FRAME_TIMER_EN undefined: new_frame derives from vsync_in only; no timer logic is built.
// TESTING (sim params: DEBOUNCE_CYCLES=4, NEW_GAME_CYCLES=3, FRAME_CYCLES=10)
// - Reset: release rst_n_in -> new_game=1 for exactly 3 cycles, then 0. Other outputs are 0 throughout.
// - Bounce: toggle btn_hit_in every 2 cycles for 20 cycles, then hold 1 with state_in=0 from H_ARMED
//   -> charging_hit stays 0 during the bounce; it rises 2+4+2 cycles after the final edge.
// - Held-over hit: hold btn_hit while state_in=3, then set state_in=0 -> charging_hit stays 0.
//   Release then press again -> charging_hit goes high.
// - Pans: press left and right together -> both 0. Release right -> camera_pan_left=1 after 2+4+1 cycles.
// - Frames: 5 vsync pulses, with new_game fired between the 2nd and 3rd -> frame_count reads 3 at the end.
//   Build with FRAME_TIMER_EN -> a pulse every 10 cycles.
// - Reset mid-charge: assert rst_n_in while charging_hit=1 -> all outputs reach their reset values immediately, with no clock edge.

Source files
------------

// File: rtl/gameplay_input_ctrl.sv
// ---------------------------------------------------------------------------
// gameplay_input_ctrl
//
// Conditions the board inputs for the gameplay core. It synchronises and
// debounces the raw buttons, turns them into the core's control levels and
// pulses, issues a hit only when the ball is at rest, and generates the
// per-frame tick together with a frame counter.
//
// Optional build macro:
//   FRAME_TIMER_EN  new_frame comes from an internal FRAME_CYCLES timer
//                   instead of vsync_in (vsync_in and VSYNC_POL are ignored)
//
// Ports:
//   clk_in             system clock
//   rst_n_in           asynchronous active-low reset
//   btn_hit_in         raw hit button (async, bouncy)
//   btn_left_in        raw pan-left button
//   btn_right_in       raw pan-right button
//   btn_reset_in       raw new-game button
//   vsync_in           video vsync (async)
//   gameplay_state_in  core state_out (0 = resting, 1 = charging hit)
//   new_game           synchronous reset pulse to the core
//   charging_hit       high while a hit is being charged
//   camera_pan_left    pan-left level
//   camera_pan_right   pan-right level
//   new_frame          one-cycle pulse per frame
//   frame_count        frames since the last new_game, wraps at 2^16
// ---------------------------------------------------------------------------
module gameplay_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned NEW_GAME_CYCLES = 4,
    parameter bit          VSYNC_POL       = 1'b1,
    parameter int unsigned FRAME_CYCLES    = 1_666_667
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        btn_hit_in,
    input  logic        btn_left_in,
    input  logic        btn_right_in,
    input  logic        btn_reset_in,
    input  logic        vsync_in,
    input  logic [2:0]  gameplay_state_in,
    output logic        new_game,
    output logic        charging_hit,
    output logic        camera_pan_left,
    output logic        camera_pan_right,
    output logic        new_frame,
    output logic [15:0] frame_count
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned NG_W = $clog2(NEW_GAME_CYCLES + 1);

    // Bit positions in the synchroniser vector.
    localparam int unsigned I_HIT   = 0;
    localparam int unsigned I_LEFT  = 1;
    localparam int unsigned I_RIGHT = 2;
    localparam int unsigned I_RESET = 3;
    localparam int unsigned I_VSYNC = 4;

    typedef enum logic [1:0] {H_IDLE, H_ARMED, H_CHARGE} hit_state_t;

    logic [4:0]      raw_in, sync_a, sync_b;
    logic [3:0]      db;
    logic            db_reset_q, reset_rise;
    logic            ng_next;
    logic [NG_W-1:0] ng_cnt, ng_cnt_next;
    logic            frame_tick;
    hit_state_t      hit_state;

    assign raw_in = {vsync_in, btn_reset_in, btn_right_in, btn_left_in, btn_hit_in};

    // Two-flop synchronisers for all asynchronous inputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
        end
    end

    // Per-button debounce: the stable value follows the synced input only
    // after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    for (genvar g = 0; g < 4; g++) begin : g_db
        logic            stable;
        logic [DB_W-1:0] cnt;

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                stable <= 1'b0;
                cnt    <= '0;
            end else if (sync_b[g] == stable) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_b[g];
                cnt    <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end

        assign db[g] = stable;
    end

    assign reset_rise = db[I_RESET] & ~db_reset_q;

    // new_game next state is computed combinationally so that every output
    // it clears is already cleared on the same edge new_game rises.
    always_comb begin
        ng_next     = new_game;
        ng_cnt_next = ng_cnt;
        if (reset_rise) begin
            ng_next     = 1'b1;
            ng_cnt_next = '0;
        end else if (new_game) begin
            if (ng_cnt == NG_W'(NEW_GAME_CYCLES - 1)) begin
                ng_next     = 1'b0;
                ng_cnt_next = '0;
            end else begin
                ng_cnt_next = ng_cnt + NG_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            new_game   <= 1'b1;
            ng_cnt     <= '0;
            db_reset_q <= 1'b0;
        end else begin
            new_game   <= ng_next;
            ng_cnt     <= ng_cnt_next;
            db_reset_q <= db[I_RESET];
        end
    end

    // Pan levels; pressing both buttons cancels out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            camera_pan_left  <= 1'b0;
            camera_pan_right <= 1'b0;
        end else if (ng_next) begin
            camera_pan_left  <= 1'b0;
            camera_pan_right <= 1'b0;
        end else begin
            camera_pan_left  <= db[I_LEFT] & ~db[I_RIGHT];
            camera_pan_right <= db[I_RIGHT] & ~db[I_LEFT];
        end
    end

    // Hit FSM: a hit is armed only once the ball rests with the button up,
    // so a button held over from before the ball stopped needs a release.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_state    <= H_IDLE;
            charging_hit <= 1'b0;
        end else if (ng_next) begin
            hit_state    <= H_IDLE;
            charging_hit <= 1'b0;
        end else begin
            charging_hit <= (hit_state == H_CHARGE);
            case (hit_state)
                H_IDLE: begin
                    if (gameplay_state_in == 3'd0 && !db[I_HIT])
                        hit_state <= H_ARMED;
                end
                H_ARMED: begin
                    if (db[I_HIT])
                        hit_state <= H_CHARGE;
                    else if (gameplay_state_in != 3'd0 && gameplay_state_in != 3'd1)
                        hit_state <= H_IDLE;
                end
                H_CHARGE: begin
                    if (!db[I_HIT])
                        hit_state <= H_IDLE;
                end
                default: hit_state <= H_IDLE;
            endcase
        end
    end

`ifdef FRAME_TIMER_EN
    localparam int unsigned FT_W = $clog2(FRAME_CYCLES);
    logic [FT_W-1:0] frame_timer;

    assign frame_tick = (frame_timer == FT_W'(FRAME_CYCLES - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            frame_timer <= '0;
        else if (frame_tick)
            frame_timer <= '0;
        else
            frame_timer <= frame_timer + FT_W'(1);
    end
`else
    logic vsync_prev;

    assign frame_tick = (sync_b[I_VSYNC] == VSYNC_POL) && (vsync_prev != VSYNC_POL);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            vsync_prev <= 1'b0;
        else
            vsync_prev <= sync_b[I_VSYNC];
    end
`endif

    // new_frame keeps pulsing during new_game; only the count is cleared.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            new_frame   <= 1'b0;
            frame_count <= '0;
        end else begin
            new_frame <= frame_tick;
            if (ng_next)
                frame_count <= '0;
            else if (frame_tick)
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_gameplay_input_ctrl.sv
module tb_gameplay_input_ctrl;

    localparam int unsigned DB  = 4;
    localparam int unsigned NG  = 3;
    localparam int unsigned FC  = 10;
    localparam int          OFF = 8;
    localparam int          N   = 4096;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        btn_hit_in = 1'b0, btn_left_in = 1'b0, btn_right_in = 1'b0;
    logic        btn_reset_in = 1'b0, vsync_in = 1'b0;
    logic [2:0]  gameplay_state_in = 3'd0;
    logic        new_game, charging_hit, camera_pan_left, camera_pan_right, new_frame;
    logic [15:0] frame_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    gameplay_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .NEW_GAME_CYCLES(NG),
        .VSYNC_POL(1'b1),
        .FRAME_CYCLES(FC)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .btn_hit_in(btn_hit_in),
        .btn_left_in(btn_left_in),
        .btn_right_in(btn_right_in),
        .btn_reset_in(btn_reset_in),
        .vsync_in(vsync_in),
        .gameplay_state_in(gameplay_state_in),
        .new_game(new_game),
        .charging_hit(charging_hit),
        .camera_pan_left(camera_pan_left),
        .camera_pan_right(camera_pan_right),
        .new_frame(new_frame),
        .frame_count(frame_count)
    );

    always #5 clk_in = ~clk_in;

    // Reference model state. History arrays are indexed by clock edge number
    // (plus OFF so lookbacks before release read zeros). raw[b][k] is the
    // value of input b seen at edge k; dbm[b][t] is the debounced value
    // after edge t.
    bit       raw [5][N];
    bit       dbm [4][N];
    bit [2:0] gsh [N];
    int       t = 0;
    int       last_trig = 0;
    int       phase = 0;          // 0 waiting, 1 ready to hit, 2 charging
    bit [15:0] m_fc = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic step();
        bit ng_m, nf_m, pl, pr, ch, flip, hit_db;
        raw[0][t+1+OFF] = btn_hit_in;
        raw[1][t+1+OFF] = btn_left_in;
        raw[2][t+1+OFF] = btn_right_in;
        raw[3][t+1+OFF] = btn_reset_in;
        raw[4][t+1+OFF] = vsync_in;
        gsh[t+1+OFF]    = gameplay_state_in;
        @(posedge clk_in);
        #1;
        t++;
        // A button's clean value flips once its input has shown the opposite
        // value for DB consecutive samples, two cycles of sync delay back.
        for (int b = 0; b < 4; b++) begin
            flip = 1'b1;
            for (int k = t - int'(DB) - 1; k <= t - 2; k++)
                if (raw[b][k+OFF] == dbm[b][t-1+OFF]) flip = 1'b0;
            dbm[b][t+OFF] = dbm[b][t-1+OFF] ^ flip;
        end
        if (dbm[3][t-1+OFF] && !dbm[3][t-2+OFF]) last_trig = t;
        ng_m = (t - last_trig) < int'(NG);
        pl = !ng_m && dbm[1][t-1+OFF] && !dbm[2][t-1+OFF];
        pr = !ng_m && dbm[2][t-1+OFF] && !dbm[1][t-1+OFF];
        hit_db = dbm[0][t-1+OFF];
        if (ng_m) begin
            ch = 1'b0;
            phase = 0;
        end else begin
            ch = (phase == 2);
            if (phase == 0) begin
                if (gsh[t+OFF] == 3'd0 && !hit_db) phase = 1;
            end else if (phase == 1) begin
                if (hit_db) phase = 2;
                else if (gsh[t+OFF] > 3'd1) phase = 0;
            end else begin
                if (!hit_db) phase = 0;
            end
        end
`ifdef FRAME_TIMER_EN
        nf_m = (t % int'(FC)) == 0;
`else
        nf_m = raw[4][t-2+OFF] && !raw[4][t-3+OFF];
`endif
        m_fc = ng_m ? 16'd0 : m_fc + 16'(nf_m);
        check("new_game", new_game, ng_m);
        check("charging_hit", charging_hit, ch);
        check("pan_left", camera_pan_left, pl);
        check("pan_right", camera_pan_right, pr);
        check("new_frame", new_frame, nf_m);
        check("frame_count", frame_count, m_fc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_new_game", new_game, 1);
        check("rst_charging", charging_hit, 0);
        check("rst_frame_count", frame_count, 0);
        rst_n_in = 1'b1;

        // Reset release: new_game for exactly NG cycles.
        run(2);
        check("ng_held", new_game, 1);
        step();
        check("ng_done", new_game, 0);
        run(5);

        // Bounce on the hit button starting from the armed state.
        gameplay_state_in = 3'd0;
        btn_hit_in = 1'b0;
        run(10);
        for (int i = 0; i < 10; i++) begin
            btn_hit_in = ~btn_hit_in;
            run(2);
            check("bounce_no_hit", charging_hit, 0);
        end
        btn_hit_in = 1'b1;
        run(7);
        check("bounce_hit_early", charging_hit, 0);
        step();
        check("bounce_hit_rise", charging_hit, 1);

        // Hit button held over from before the ball came to rest.
        gameplay_state_in = 3'd3;
        btn_hit_in = 1'b0;
        run(10);
        btn_hit_in = 1'b1;
        run(10);
        gameplay_state_in = 3'd0;
        run(10);
        check("held_over_hit", charging_hit, 0);
        btn_hit_in = 1'b0;
        run(10);
        btn_hit_in = 1'b1;
        run(10);
        check("rearmed_hit", charging_hit, 1);
        btn_hit_in = 1'b0;
        run(10);

        // Pans: both buttons cancel; releasing right leaves left.
        btn_left_in = 1'b1;
        btn_right_in = 1'b1;
        run(12);
        check("pan_both_l", camera_pan_left, 0);
        check("pan_both_r", camera_pan_right, 0);
        btn_right_in = 1'b0;
        run(6);
        check("pan_left_early", camera_pan_left, 0);
        step();
        check("pan_left_rise", camera_pan_left, 1);
        btn_left_in = 1'b0;
        run(10);

        // Five vsync pulses with a new game between the 2nd and 3rd.
        for (int p = 1; p <= 5; p++) begin
            vsync_in = 1'b1;
            run(3);
            vsync_in = 1'b0;
            run(5);
            if (p == 2) begin
                btn_reset_in = 1'b1;
                run(8);
                btn_reset_in = 1'b0;
                run(10);
            end
        end
        run(4);
`ifndef FRAME_TIMER_EN
        check("frames_after_new_game", frame_count, 3);
`endif

        // Randomised traffic on all inputs.
        for (int i = 0; i < 1500 && t < N - OFF - 4; i++) begin
            if ($urandom_range(0, 7) == 0) btn_hit_in   = ~btn_hit_in;
            if ($urandom_range(0, 7) == 0) btn_left_in  = ~btn_left_in;
            if ($urandom_range(0, 7) == 0) btn_right_in = ~btn_right_in;
            if ($urandom_range(0, 29) == 0) btn_reset_in = ~btn_reset_in;
            if ($urandom_range(0, 3) == 0) vsync_in     = ~vsync_in;
            if ($urandom_range(0, 9) == 0)
                gameplay_state_in = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 5));
            step();
        end

        // Reset while a hit is charging: outputs return without a clock edge.
        btn_reset_in = 1'b0;
        btn_left_in = 1'b1;
        btn_right_in = 1'b0;
        btn_hit_in = 1'b0;
        gameplay_state_in = 3'd0;
        run(20);
        btn_hit_in = 1'b1;
        run(10);
        check("pre_reset_charging", charging_hit, 1);
        check("pre_reset_pan", camera_pan_left, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async_new_game", new_game, 1);
        check("async_charging", charging_hit, 0);
        check("async_pan_left", camera_pan_left, 0);
        check("async_pan_right", camera_pan_right, 0);
        check("async_new_frame", new_frame, 0);
        check("async_frame_count", frame_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
